// File: rtl/display_scan_if.sv
// Handshake bundle between the display scan controller and its user.
// The controller uses the slave side; the user or bench uses the master side.
interface display_scan_if #(
   parameter int NUM_DIGITS = 4,
   parameter int BRIGHT_W   = 3
);
   localparam int DW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

   logic                  en;
   logic [NUM_DIGITS-1:0] digit_en;
   logic [BRIGHT_W-1:0]   brightness;
   logic [NUM_DIGITS-1:0] anode;
   logic [DW-1:0]         digit_sel;
   logic                  slot_start;

   modport master (
      output en, digit_en, brightness,
      input  anode, digit_sel, slot_start
   );

   modport slave (
      input  en, digit_en, brightness,
      output anode, digit_sel, slot_start
   );
endinterface

// File: rtl/display_scan_controller.sv
// Multiplexed 7-seg anode scanner with dead-time blanking,
// digit skipping and PWM brightness.
module display_scan_controller #(
   parameter int NUM_DIGITS  = 4,
   parameter int CLK_DIV     = 100000,
   parameter int DEAD_CYCLES = 1000,
   parameter int BRIGHT_W    = 3,
   parameter int ACTIVE_LOW  = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   display_scan_if.slave bus
);
   localparam int DW    = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
   localparam int SW    = $clog2(CLK_DIV);
   localparam int PWRAP = (1 << BRIGHT_W) - 2;
   localparam logic [NUM_DIGITS-1:0] OFF =
      {NUM_DIGITS{ACTIVE_LOW != 0}};

   typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

   state_t                state, state_n, first_st;
   logic [SW-1:0]         slot_cnt, slot_n;
   logic [BRIGHT_W-1:0]   pwm_cnt, pwm_n;
   logic [DW-1:0]         sel_n, low_idx, next_idx, cand;
   logic [NUM_DIGITS-1:0] anode_n;
   logic                  start_n, slot_end, found;

   assign slot_end = (slot_cnt == SW'(CLK_DIV - 1));
   assign first_st = (DEAD_CYCLES == 0) ? DRIVE : BLANK;

   // Enabled-digit search: lowest index, and next index with wrap.
   always_comb begin
      low_idx  = bus.digit_sel;
      next_idx = bus.digit_sel;
      cand     = '0;
      found    = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         cand = DW'(i);
         if (bus.digit_en[cand]) low_idx = cand;
      end
      for (int k = 1; k <= NUM_DIGITS; k++) begin
         cand = DW'((int'(bus.digit_sel) + k) % NUM_DIGITS);
         if (!found && bus.digit_en[cand]) begin
            next_idx = cand;
            found    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      if (!bus.en) begin
         state_n = IDLE;
      end else begin
         case (state)
            IDLE:    state_n = first_st;
            default: begin
               if (slot_end)
                  state_n = first_st;
               else if (int'(slot_cnt) + 1 >= DEAD_CYCLES)
                  state_n = DRIVE;
               else
                  state_n = BLANK;
            end
         endcase
      end
   end

   // Next values of counters and registered outputs.
   always_comb begin
      slot_n  = '0;
      pwm_n   = '0;
      sel_n   = bus.digit_sel;
      start_n = 1'b0;
      if (bus.en) begin
         if (state == IDLE) begin
            start_n = 1'b1;
            sel_n   = low_idx;
         end else if (slot_end) begin
            start_n = 1'b1;
            sel_n   = next_idx;
         end else begin
            slot_n = slot_cnt + 1'b1;
            if (state == DRIVE)
               pwm_n = (pwm_cnt == BRIGHT_W'(PWRAP)) ?
                       '0 : pwm_cnt + 1'b1;
         end
      end
      anode_n = OFF;
      if (state_n == DRIVE && pwm_n < bus.brightness &&
          bus.digit_en[sel_n])
         anode_n = OFF ^ (NUM_DIGITS'(1) << sel_n);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_cnt       <= '0;
         pwm_cnt        <= '0;
         bus.digit_sel  <= '0;
         bus.slot_start <= 1'b0;
         bus.anode      <= OFF;
      end else begin
         slot_cnt       <= slot_n;
         pwm_cnt        <= pwm_n;
         bus.digit_sel  <= sel_n;
         bus.slot_start <= start_n;
         bus.anode      <= anode_n;
      end
   end
endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: slot-position model plus
// directed scenarios with literal expectations.
module tb_display_scan_controller;
   localparam int N    = 4;
   localparam int CDIV = 8;
   localparam int DEAD = 2;
   localparam int BW   = 3;
   localparam int PER  = (1 << BW) - 1;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   display_scan_if #(.NUM_DIGITS(N), .BRIGHT_W(BW)) bus ();

   display_scan_controller #(
      .NUM_DIGITS(N), .CLK_DIV(CDIV), .DEAD_CYCLES(DEAD),
      .BRIGHT_W(BW), .ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic int lowest(input logic [N-1:0] d, input int cur);
      int r;
      r = cur;
      for (int i = N - 1; i >= 0; i--) if (d[i]) r = i;
      return r;
   endfunction

   function automatic int after(input logic [N-1:0] d, input int cur);
      int r;
      r = cur;
      for (int k = N; k >= 1; k--) if (d[(cur + k) % N]) r = (cur + k) % N;
      return r;
   endfunction

   // Model: position within the current slot and owning digit.
   logic          m_run;
   int            m_pos, m_sel;
   logic [N-1:0]  m_den;
   logic [BW-1:0] m_br;
   logic [N-1:0]  e_an;
   logic          e_st;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run <= 1'b0;
         m_pos <= 0;
         m_sel <= 0;
         m_den <= '0;
         m_br  <= '0;
      end else begin
         m_den <= bus.digit_en;
         m_br  <= bus.brightness;
         if (!bus.en) begin
            m_run <= 1'b0;
            m_pos <= 0;
         end else if (!m_run) begin
            m_run <= 1'b1;
            m_pos <= 0;
            m_sel <= lowest(bus.digit_en, m_sel);
         end else if (m_pos == CDIV - 1) begin
            m_pos <= 0;
            m_sel <= after(bus.digit_en, m_sel);
         end else begin
            m_pos <= m_pos + 1;
         end
      end
   end

   always_comb begin
      e_an = '1;
      e_st = m_run && (m_pos == 0);
      if (m_run && m_pos >= DEAD && ((m_pos - DEAD) % PER) < int'(m_br)
          && m_den[m_sel])
         e_an = ~(N'(1) << m_sel);
   end

   always @(negedge clk) begin
      chk("model_anode", bus.anode, e_an);
      chk("model_digit_sel", bus.digit_sel, m_sel);
      chk("model_slot_start", bus.slot_start, e_st);
      chk("one_active", $countones(~bus.anode) <= 1, 1);
   end

   task automatic wait_slot(input int want);
      bit ok;
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (bus.slot_start && (want < 0 || int'(bus.digit_sel) == want))
            ok = 1;
      end
      chk("slot_wait_timeout", ok, 1);
   endtask

   logic [N-1:0] pat[4];
   logic [N-1:0] p4[8];
   bit           seen_e, seen_b;
   int           pulses, last;

   initial begin
      pat = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      p4  = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hF};
      rst_n = 1'b0;
      bus.en = 1'b0;
      bus.digit_en = 4'hF;
      bus.brightness = 3'd7;
      #23 rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("reset_anode", bus.anode, 4'hF);
         chk("reset_sel", bus.digit_sel, 0);
         chk("reset_start", bus.slot_start, 0);
      end

      bus.en = 1'b1;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         chk("scan_anode", bus.anode, (i % 8 < 2) ? 4'hF : pat[i / 8]);
         chk("scan_start", bus.slot_start, (i % 8 == 0));
      end
      @(negedge clk);
      chk("wrap_sel", bus.digit_sel, 0);
      chk("wrap_start", bus.slot_start, 1);

      bus.digit_en = 4'b0101;
      seen_e = 0;
      seen_b = 0;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         chk("skip_anode", (bus.anode == 4'b1101) || (bus.anode == 4'b0111), 0);
         if (bus.anode == 4'b1110) seen_e = 1;
         if (bus.anode == 4'b1011) seen_b = 1;
      end
      chk("skip_seen_d0", seen_e, 1);
      chk("skip_seen_d2", seen_b, 1);

      bus.brightness = 3'd3;
      bus.digit_en = 4'b0001;
      wait_slot(-1);
      chk("pwm3_anode_0", bus.anode, p4[0]);
      for (int p = 1; p < 8; p++) begin
         @(negedge clk);
         chk("pwm3_anode", bus.anode, p4[p]);
      end
      bus.brightness = 3'd0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk("pwm0_anode", bus.anode, 4'hF);
      end

      bus.brightness = 3'd7;
      bus.digit_en = 4'hF;
      wait_slot(1);
      repeat (5) @(negedge clk);
      chk("d1_drive4_anode", bus.anode, 4'b1101);
      bus.en = 1'b0;
      @(negedge clk);
      chk("off_anode", bus.anode, 4'hF);
      chk("off_sel", bus.digit_sel, 1);
      chk("off_start", bus.slot_start, 0);
      repeat (2) @(negedge clk);
      bus.en = 1'b1;
      @(negedge clk);
      chk("reen_start", bus.slot_start, 1);
      chk("reen_sel", bus.digit_sel, 0);
      chk("reen_anode", bus.anode, 4'hF);

      repeat (3) @(negedge clk);
      chk("pre_rst_anode", bus.anode, 4'b1110);
      #1 rst_n = 1'b0;
      #1 chk("async_rst_anode", bus.anode, 4'hF);
      chk("async_rst_sel", bus.digit_sel, 0);
      #2 rst_n = 1'b1;

      @(negedge clk);
      bus.digit_en = 4'h0;
      pulses = 0;
      last = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         chk("den0_anode", bus.anode, 4'hF);
         if (bus.slot_start) begin
            if (last >= 0) chk("den0_period", i - last, 8);
            last = i;
            pulses++;
         end
      end
      chk("den0_pulses", pulses, 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
